// File: rtl/fetch_unit_if.sv
// fetch_unit_if: memory request/response, redirect and decode-side handshakes of the fetch stage
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, if_ready
  );
  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
    output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, if_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: credit-limited sequential instruction fetch with an in-order queue and redirect squashing
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);
  localparam int P = $clog2(DEPTH);
  localparam int W = P + 1;
  localparam logic [W:0] LIM = DEPTH[W:0];
  logic          run;
  logic [31:0]   fetch_pc, resp_pc, target;
  logic [W-1:0]  count, outstanding, drop_cnt, out_next;
  logic [P-1:0]  head, tail;
  logic [31:0]   q_pc [DEPTH];
  logic [31:0]   q_instr [DEPTH];
  logic          req_fire, resp_ok, drop, push, pop;
  // run holds the request port quiet for the reset cycle itself
  assign bus.imem_req_valid = run & (({1'b0, outstanding} + {1'b0, count}) < LIM);
  assign bus.imem_req_addr  = fetch_pc;
  assign bus.if_valid       = count != '0;
  assign bus.if_pc          = q_pc[head];
  assign bus.if_instr       = q_instr[head];
  assign target   = bus.redirect_pc & 32'hFFFF_FFFC;
  assign req_fire = bus.imem_req_valid & bus.imem_req_ready;
  assign resp_ok  = bus.imem_resp_valid & (outstanding != '0);
  assign drop     = resp_ok & (drop_cnt != '0);
  assign push     = resp_ok & (drop_cnt == '0) & ~bus.redirect_valid;
  assign pop      = bus.if_valid & bus.if_ready;
  assign out_next = outstanding + W'(req_fire) - W'(resp_ok);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run         <= 1'b0;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      head        <= '0;
      tail        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_pc[i]    <= '0;
        q_instr[i] <= '0;
      end
    end else begin
      run         <= 1'b1;
      outstanding <= out_next;
      if (bus.redirect_valid) begin
        // everything still in flight after this edge belongs to the old stream
        fetch_pc <= target;
        resp_pc  <= target;
        count    <= '0;
        head     <= '0;
        tail     <= '0;
        drop_cnt <= out_next;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (push) begin
          q_pc[tail]    <= resp_pc;
          q_instr[tail] <= bus.imem_resp_data;
          tail          <= tail + P'(1);
          resp_pc       <= resp_pc + 32'd4;
        end
        if (pop) head <= head + P'(1);
        if (drop) drop_cnt <= drop_cnt - W'(1);
        count <= count + W'(push) - W'(pop);
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized memory/decode environment with a scoreboard of expected delivered PCs
module tb_fetch_unit;
  localparam logic [31:0] RPC = 32'h0000_0100;
  typedef struct { logic [31:0] a; int due; } req_t;
  logic clk = 0;
  logic rst_n = 0;
  fetch_unit_if bus();
  fetch_unit #(.RESET_PC(RPC), .DEPTH(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  int pops = 0;
  int cyc = 0;
  int lat_min = 1, lat_max = 1, mem_rdy = 100, ifr_pct = 0;
  req_t pend[$];
  logic [31:0] exp_q[$];
  logic [31:0] next_exp = RPC;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.imem_req_ready  = 0;
    bus.imem_resp_valid = 0;
    bus.imem_resp_data  = 0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.imem_req_valid && bus.imem_req_ready)
        pend.push_back('{a: bus.imem_req_addr, due: cyc + $urandom_range(lat_max, lat_min)});
      @(posedge clk);
      #2;
      cyc++;
      bus.imem_resp_valid = 0;
      if (!rst_n) pend.delete();
      else if (pend.size() != 0 && pend[0].due <= cyc) begin
        req_t r;
        r = pend.pop_front();
        bus.imem_resp_valid = 1;
        bus.imem_resp_data  = mem_word(r.a);
      end
      bus.imem_req_ready = $urandom_range(99) < mem_rdy;
    end
  end
  initial begin
    bus.if_ready = 0;
    forever begin
      @(posedge clk);
      #1;
      bus.if_ready = $urandom_range(99) < ifr_pct;
    end
  end
  always @(negedge clk) begin
    if (rst_n && bus.if_valid && bus.if_ready) begin
      logic [31:0] e;
      pops++;
      if (exp_q.size() == 0) begin
        exp_q.push_back(next_exp);
        next_exp = next_exp + 32'd4;
      end
      e = exp_q.pop_front();
      chk("if_pc", bus.if_pc, e);
      chk("if_instr", bus.if_instr, mem_word(e));
    end
  end
  task automatic redirect(input logic [31:0] t);
    logic [31:0] tt;
    tt = t & 32'hFFFF_FFFC;
    @(posedge clk);
    #1;
    bus.redirect_valid = 1;
    bus.redirect_pc    = t;
    @(negedge clk);
    #1;
    exp_q.delete();
    for (int k = 0; k < 4; k++) exp_q.push_back(tt + 32'(4 * k));
    next_exp = tt + 32'd16;
    @(posedge clk);
    #1;
    bus.redirect_valid = 0;
    @(negedge clk);
    chk("redir_if_valid", {31'b0, bus.if_valid}, 32'd0);
    if (bus.imem_req_valid) chk("redir_req_addr", bus.imem_req_addr, tt);
  endtask
  initial begin
    int p0;
    logic [31:0] t;
    bus.redirect_valid = 0;
    bus.redirect_pc    = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    chk("rst_if_valid", {31'b0, bus.if_valid}, 32'd0);
    chk("rst_req_addr", bus.imem_req_addr, RPC);
    chk("rst_if_pc", bus.if_pc, 32'd0);
    chk("rst_if_instr", bus.if_instr, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1;
    ifr_pct = 100;
    @(posedge clk);
    @(negedge clk);
    chk("first_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
    chk("first_req_addr", bus.imem_req_addr, RPC);
    repeat (10) @(posedge clk);
    p0 = pops;
    repeat (60) @(posedge clk);
    chk("throughput", {31'b0, (pops - p0) >= 36}, 32'd1);
    ifr_pct = 0;
    lat_min = 1;
    lat_max = 3;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("bp_if_valid", {31'b0, bus.if_valid}, 32'd1);
    chk("bp_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    ifr_pct = 100;
    repeat (20) @(posedge clk);
    lat_min = 3;
    lat_max = 3;
    repeat (10) @(posedge clk);
    redirect(32'h0000_2003);
    repeat (20) @(posedge clk);
    lat_min = 1;
    lat_max = 1;
    redirect(32'hFFFF_FFFC);
    repeat (20) @(posedge clk);
    for (int it = 0; it < 600; it++) begin
      if (it % 100 == 0) begin
        lat_min = $urandom_range(2, 1);
        lat_max = lat_min + $urandom_range(3);
        mem_rdy = $urandom_range(100, 40);
        ifr_pct = $urandom_range(100, 30);
      end
      if ($urandom_range(99) < 6) begin
        t = $urandom;
        if (t[4:3] == 2'b00) t = 32'hFFFF_FFF0 | (t & 32'hF);
        redirect(t);
      end else @(posedge clk);
    end
    mem_rdy = 100;
    lat_min = 3;
    lat_max = 3;
    ifr_pct = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.if_valid && !bus.imem_req_valid) break;
    end
    chk("full_before_reset", {30'b0, bus.if_valid, bus.imem_req_valid}, 32'd2);
    @(posedge clk);
    #1;
    rst_n = 0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("midrst_if_valid", {31'b0, bus.if_valid}, 32'd0);
    chk("midrst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    @(posedge clk);
    #1;
    next_exp = RPC;
    rst_n = 1;
    ifr_pct = 100;
    @(posedge clk);
    @(negedge clk);
    chk("restart_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
    chk("restart_req_addr", bus.imem_req_addr, RPC);
    repeat (30) @(posedge clk);
    chk("enough_pops", {31'b0, pops >= 200}, 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
